// File: rtl/arb_8_mux_ctrl_if.sv
// Request/grant bundle between the requesting units and the arb_8_mux_ctrl arbiter.
// The arbiter (slave) takes req/done and drives the grant and mux-select outputs.
interface arb_8_mux_ctrl_if;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic       sel2;
   logic       sel1;
   logic       sel0;
   logic       busy;
   logic       timeout;

   modport master (
      output req, done,
      input  gnt, sel2, sel1, sel0, busy, timeout
   );

   modport slave (
      input  req, done,
      output gnt, sel2, sel1, sel0, busy, timeout
   );
endinterface

// File: rtl/arb_8_mux_ctrl.sv
// Round-robin arbiter for the 8:1 one-bit mux: grants one requester at a time,
// drives the mux select with the owner index and releases on done, withdrawal or hold limit.
module arb_8_mux_ctrl #(
   parameter int unsigned HOLD_MAX = 15
) (
   input  logic             clk,
   input  logic             rst,
   arb_8_mux_ctrl_if.slave  bus
);

   localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state_q, state_d;
   logic [2:0] ptr_q,   ptr_d;
   logic [3:0] cnt_q,   cnt_d;
   logic [2:0] sel_q,   sel_d;
   logic [7:0] gnt_q,   gnt_d;
   logic       busy_q,  busy_d;
   logic       timeout_q, timeout_d;

   // Requests rotated so that bit 0 is the current round-robin start position.
   logic [7:0] rot_req;
   logic [2:0] rot_off;
   logic [2:0] pick_idx;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_rot
         assign rot_req[gi] = bus.req[ptr_q + 3'(gi)];
      end
   endgenerate

   always_comb begin
      rot_off = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (rot_req[i]) rot_off = 3'(i);
      end
   end

   assign pick_idx = ptr_q + rot_off;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      sel_d     = sel_q;
      gnt_d     = gnt_q;
      busy_d    = busy_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               gnt_d   = 8'b1 << pick_idx;
               sel_d   = pick_idx;
               busy_d  = 1'b1;
               cnt_d   = 4'd1;
               state_d = GRANT;
            end
         end
         GRANT: begin
            // sel_q holds the owner index for the whole grant.
            if (bus.done || !bus.req[sel_q] || (cnt_q == HOLD_LIM)) begin
               timeout_d = !bus.done && bus.req[sel_q];
               gnt_d     = 8'd0;
               busy_d    = 1'b0;
               cnt_d     = 4'd0;
               ptr_d     = sel_q + 3'd1;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= 3'd0;
         cnt_q     <= 4'd0;
         sel_q     <= 3'd0;
         gnt_q     <= 8'd0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         sel_q     <= sel_d;
         gnt_q     <= gnt_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.sel2    = sel_q[2];
   assign bus.sel1    = sel_q[1];
   assign bus.sel0    = sel_q[0];
   assign bus.busy    = busy_q;
   assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_arb_8_mux_ctrl.sv
// Bench for arb_8_mux_ctrl: an owner/pointer model checked every cycle, plus directed
// scenarios with literal expectations for reset, rotation, wrap, hold limit and withdrawal.
module tb_arb_8_mux_ctrl;
   localparam int HM = 15;

   logic clk;
   logic rst;
   arb_8_mux_ctrl_if bus ();

   arb_8_mux_ctrl #(.HOLD_MAX(HM)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   wire [2:0] sel_w = {bus.sel2, bus.sel1, bus.sel0};

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 0;

   // Model state: owner is -1 when nobody holds the mux.
   int owner   = -1;
   int held    = 0;
   int rr_ptr  = 0;
   int last_sel = 0;
   bit m_tmo   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Model: ownership and round-robin pointer tracked as plain integers.
   always @(posedge clk) begin
      m_tmo = 0;
      if (rst) begin
         owner = -1; held = 0; rr_ptr = 0; last_sel = 0;
      end else if (owner < 0) begin
         for (int k = 0; k < 8; k++) begin
            if (owner < 0 && bus.req[(rr_ptr + k) % 8]) begin
               owner = (rr_ptr + k) % 8;
            end
         end
         if (owner >= 0) begin
            last_sel = owner;
            held = 1;
         end
      end else if (bus.done || !bus.req[owner] || held == HM) begin
         m_tmo = !(bus.done || !bus.req[owner]);
         rr_ptr = (owner + 1) % 8;
         owner = -1;
      end else begin
         held++;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic [7:0] eg;
         eg = (owner < 0) ? 8'h00 : (8'h01 << owner);
         check("cycle", {3'b0, bus.gnt, sel_w, bus.busy, bus.timeout},
               {3'b0, eg, 3'(last_sel), owner >= 0, m_tmo});
      end
   end

   task automatic do_reset();
      rst = 1'b1; bus.req = 8'h00; bus.done = 1'b0;
      tick(2);
      chk_en = 1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; bus.req = 8'hFF; bus.done = 1'b0;
      tick(2);
      chk_en = 1;
      check("rst_gnt", 16'(bus.gnt), 16'h00);
      check("rst_sel", 16'(sel_w), 16'h0);
      check("rst_busy_tmo", {14'b0, bus.busy, bus.timeout}, 16'h0);
      rst = 1'b0;
      tick(1);
      check("first_gnt", 16'(bus.gnt), 16'h01);

      // Single requester with done in the third grant cycle
      do_reset();
      bus.req = 8'h20;
      tick(1);
      check("single_gnt", 16'(bus.gnt), 16'h20);
      check("single_sel", 16'(sel_w), 16'h5);
      tick(2);
      check("single_c3", 16'(bus.gnt), 16'h20);
      bus.done = 1'b1;
      tick(1);
      bus.done = 1'b0;
      check("single_rel", {bus.gnt, 5'b0, sel_w}, {8'h00, 5'b0, 3'h5});
      check("single_rel_flags", {14'b0, bus.busy, bus.timeout}, 16'h0);
      bus.req = 8'h21;
      tick(1);
      check("wrap6_gnt", 16'(bus.gnt), 16'h01);
      check("wrap6_sel", 16'(sel_w), 16'h0);

      // Full load round robin
      do_reset();
      bus.req = 8'hFF; bus.done = 1'b1;
      for (int n = 0; n < 9; n++) begin
         tick(1);
         check("rr_gnt", 16'(bus.gnt), 16'(8'h01 << (n % 8)));
         check("rr_sel", 16'(sel_w), 16'(n % 8));
         tick(1);
         check("rr_bubble", 16'(bus.gnt), 16'h00);
      end

      // Wrap and priority
      do_reset();
      bus.done = 1'b0; bus.req = 8'h40;
      tick(1);
      check("wp_g6", 16'(bus.gnt), 16'h40);
      bus.done = 1'b1; bus.req = 8'h81;
      tick(1);
      check("wp_rel6", 16'(bus.gnt), 16'h00);
      tick(1);
      check("wp_g7", 16'(bus.gnt), 16'h80);
      tick(2);
      check("wp_g0", 16'(bus.gnt), 16'h01);
      tick(1);
      bus.req = 8'h80;
      tick(1);
      check("wp_g7b", 16'(bus.gnt), 16'h80);
      tick(1);
      bus.req = 8'h41;
      tick(1);
      check("wp_g0b", 16'(bus.gnt), 16'h01);
      tick(2);
      check("wp_g6b", 16'(bus.gnt), 16'h40);

      // Hold limit
      do_reset();
      bus.done = 1'b0; bus.req = 8'h09;
      tick(1);
      check("to_g0", 16'(bus.gnt), 16'h01);
      for (int c = 2; c <= HM; c++) begin
         tick(1);
         check("to_hold", {7'b0, bus.gnt, bus.timeout}, {7'b0, 8'h01, 1'b0});
      end
      tick(1);
      check("to_release", {7'b0, bus.gnt, bus.timeout}, {7'b0, 8'h00, 1'b1});
      tick(1);
      check("to_next", {7'b0, bus.gnt, bus.timeout}, {7'b0, 8'h08, 1'b0});
      tick(HM - 1);
      check("to_c15", 16'(bus.gnt), 16'h08);
      bus.done = 1'b1;
      tick(1);
      bus.done = 1'b0;
      check("done_at_limit", {7'b0, bus.gnt, bus.timeout}, {7'b0, 8'h00, 1'b0});

      // Withdrawal
      do_reset();
      bus.req = 8'h04;
      tick(2);
      check("wd_c2", 16'(bus.gnt), 16'h04);
      bus.req = 8'h00;
      tick(1);
      check("wd_rel", {6'b0, bus.gnt, bus.busy, bus.timeout}, 16'h0);

      // Reset mid-grant
      bus.req = 8'h10;
      tick(1);
      check("rm_g4", 16'(bus.gnt), 16'h10);
      tick(3);
      check("rm_c4", 16'(sel_w), 16'h4);
      rst = 1'b1;
      tick(1);
      check("rm_rst", {3'b0, bus.gnt, sel_w, bus.busy, bus.timeout}, 16'h0);
      rst = 1'b0;
      bus.req = 8'h00;
      tick(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
